// File: rtl/exception_arbiter.sv
// rtl/exception_arbiter.sv - edge-latched, masked, fixed-priority exception arbiter with in-service tracking
// Optional nested traps while in service: define EXC_NESTING_EN.
module exception_arbiter #(
   parameter int          NSRC       = 3,
   parameter int          IDW        = 2,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] src_in,
   input  logic            en_wr,
   input  logic [NSRC-1:0] en_din,
   output logic [NSRC-1:0] en_out,
   output logic            exp_req,
   output logic [IDW-1:0]  exp_id,
   output logic [31:0]     exp_vec,
   input  logic            exp_ack,
   input  logic            eret,
   output logic [NSRC-1:0] pending,
   output logic [NSRC-1:0] in_service,
   output logic            busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t          state, state_n;
   logic [NSRC-1:0] src_prev;
   logic [NSRC-1:0] pending_n, in_service_n, en_n;
   logic            exp_req_n;
   logic [IDW-1:0]  exp_id_n;
   logic [31:0]     exp_vec_n;

   logic [NSRC-1:0] rise, elig, id_oh, lowbit;
   logic [IDW-1:0]  win_id;
   logic [31:0]     win_vec;

   assign rise    = src_in & ~src_prev;
   assign elig    = pending & en_out & ~in_service;
   assign id_oh   = NSRC'(1) << exp_id;
   // Isolates the highest-priority (lowest-index) in-service level.
   assign lowbit  = in_service & (~in_service + NSRC'(1));
   assign win_vec = VEC_BASE + VEC_STRIDE * {{(32-IDW){1'b0}}, win_id};
   assign busy    = |in_service;

`ifdef EXC_NESTING_EN
   logic [NSRC-1:0] lower;
   assign lower = lowbit - NSRC'(1);
`endif

   always_comb begin
      win_id = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (elig[i]) win_id = IDW'(i);
      end
   end

   always_comb begin
      state_n      = state;
      pending_n    = pending;
      in_service_n = in_service;
      exp_req_n    = exp_req;
      exp_id_n     = exp_id;
      exp_vec_n    = exp_vec;
      en_n         = en_wr ? en_din : en_out;
      case (state)
         IDLE: begin
            if (|elig) begin
               state_n   = REQ;
               exp_req_n = 1'b1;
               exp_id_n  = win_id;
               exp_vec_n = win_vec;
            end
         end
         REQ: begin
            if (exp_ack) begin
               pending_n    = pending & ~id_oh;
               in_service_n = in_service | id_oh;
               exp_req_n    = 1'b0;
               state_n      = SERVICE;
            end
         end
         SERVICE: begin
            if (eret) begin
               in_service_n = in_service & ~lowbit;
               if (in_service_n == '0) state_n = IDLE;
            end
`ifdef EXC_NESTING_EN
            else if (|(elig & lower)) begin
               state_n   = REQ;
               exp_req_n = 1'b1;
               exp_id_n  = win_id;
               exp_vec_n = win_vec;
            end
`endif
         end
         default: state_n = IDLE;
      endcase
      // A new edge in the ack cycle must not be lost.
      pending_n = pending_n | rise;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         src_prev   <= '0;
         pending    <= '0;
         in_service <= '0;
         en_out     <= '1;
         exp_req    <= 1'b0;
         exp_id     <= '0;
         exp_vec    <= VEC_BASE;
      end else begin
         state      <= state_n;
         src_prev   <= src_in;
         pending    <= pending_n;
         in_service <= in_service_n;
         en_out     <= en_n;
         exp_req    <= exp_req_n;
         exp_id     <= exp_id_n;
         exp_vec    <= exp_vec_n;
      end
   end

endmodule

// File: tb/tb_exception_arbiter.sv
// tb/tb_exception_arbiter.sv - directed scoreboard bench for exception_arbiter
module tb_exception_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  src_in, en_din, en_out, pending, in_service;
   logic        en_wr, exp_req, exp_ack, eret, busy;
   logic [1:0]  exp_id;
   logic [31:0] exp_vec;

   int checks = 0;
   int failures = 0;
   logic [33:0] grant_q[$];

   exception_arbiter dut (
      .clk(clk), .rst(rst), .src_in(src_in), .en_wr(en_wr), .en_din(en_din),
      .en_out(en_out), .exp_req(exp_req), .exp_id(exp_id), .exp_vec(exp_vec),
      .exp_ack(exp_ack), .eret(eret), .pending(pending), .in_service(in_service),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_grant(input logic [1:0] id);
      grant_q.push_back({id, 32'h0000_0800 + 32'(id) * 32'h10});
   endtask

   task automatic expect_grant(input string tag);
      logic [33:0] g;
      int n;
      n = 0;
      while (!exp_req && n < 10) begin
         tick();
         n++;
      end
      chk({tag, "_req"}, 32'(exp_req), 32'd1);
      if (grant_q.size() == 0) begin
         chk({tag, "_queue"}, 32'd0, 32'd1);
      end else begin
         g = grant_q.pop_front();
         chk({tag, "_id"}, 32'(exp_id), 32'(g[33:32]));
         chk({tag, "_vec"}, exp_vec, g[31:0]);
      end
   endtask

   task automatic ack();
      exp_ack = 1'b1;
      tick();
      exp_ack = 1'b0;
   endtask

   task automatic do_eret();
      eret = 1'b1;
      tick();
      eret = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pend"}, 32'(pending), 32'd0);
      chk({tag, "_insv"}, 32'(in_service), 32'd0);
      chk({tag, "_en"}, 32'(en_out), 32'h7);
      chk({tag, "_req"}, 32'(exp_req), 32'd0);
      chk({tag, "_id"}, 32'(exp_id), 32'd0);
      chk({tag, "_vec"}, exp_vec, 32'h800);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; src_in = '0; en_wr = 1'b0; en_din = '0; exp_ack = 1'b0; eret = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk_reset("rst");

      // T1
      src_in = 3'b010; push_grant(2'd1);
      tick();
      src_in = 3'b000;
      chk("t1_pend", 32'(pending), 32'h2);
      chk("t1_noreq", 32'(exp_req), 32'd0);
      tick();
      chk("t1_lat", 32'(exp_req), 32'd1);
      expect_grant("t1");
      ack();
      chk("t1_insv", 32'(in_service), 32'h2);
      chk("t1_pclr", 32'(pending), 32'h0);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_reqlo", 32'(exp_req), 32'd0);
      do_eret();
      chk("t1_ret", 32'(in_service), 32'h0);

      // T2
      src_in = 3'b110; push_grant(2'd1); push_grant(2'd2);
      tick();
      src_in = 3'b000;
      tick();
      expect_grant("t2a");
      tick();
      tick();
      chk("t2_hold", 32'(exp_id), 32'd1);
      ack();
      do_eret();
      expect_grant("t2b");
      ack();
      do_eret();

      // T3
      en_wr = 1'b1; en_din = 3'b110;
      tick();
      en_wr = 1'b0;
      chk("t3_en", 32'(en_out), 32'h6);
      src_in = 3'b001;
      tick();
      src_in = 3'b000;
      tick();
      chk("t3_pend", 32'(pending), 32'h1);
      tick();
      chk("t3_masked", 32'(exp_req), 32'd0);
      en_wr = 1'b1; en_din = 3'b111; push_grant(2'd0);
      tick();
      en_wr = 1'b0;
      chk("t3_en2", 32'(en_out), 32'h7);
      chk("t3_notyet", 32'(exp_req), 32'd0);
      tick();
      chk("t3_lat", 32'(exp_req), 32'd1);
      expect_grant("t3");
      ack();
      do_eret();

      // T4
      src_in = 3'b100; push_grant(2'd2);
      tick();
      src_in = 3'b000;
      tick();
      expect_grant("t4a");
      ack();
      chk("t4_insv", 32'(in_service), 32'h4);
      src_in = 3'b001;
      tick();
      src_in = 3'b000;
`ifdef EXC_NESTING_EN
      push_grant(2'd0);
      tick();
      expect_grant("t4n");
      ack();
      chk("t4_nest", 32'(in_service), 32'h5);
      do_eret();
      chk("t4_ret1", 32'(in_service), 32'h4);
      do_eret();
      chk("t4_ret2", 32'(in_service), 32'h0);
      chk("t4_busy", 32'(busy), 32'd0);
      tick();
      chk("t4_idle", 32'(exp_req), 32'd0);
`else
      tick();
      tick();
      chk("t4_block", 32'(exp_req), 32'd0);
      chk("t4_pend", 32'(pending), 32'h1);
      do_eret();
      chk("t4_ret", 32'(in_service), 32'h0);
      push_grant(2'd0);
      tick();
      expect_grant("t4b");
      ack();
      do_eret();
      chk("t4_done", 32'(in_service), 32'h0);
`endif

      // T5
      src_in = 3'b010; push_grant(2'd1);
      tick();
      src_in = 3'b000;
      tick();
      expect_grant("t5a");
      src_in = 3'b010; exp_ack = 1'b1;
      tick();
      src_in = 3'b000; exp_ack = 1'b0;
      chk("t5_setwins", 32'(pending), 32'h2);
      chk("t5_insv", 32'(in_service), 32'h2);
      push_grant(2'd1);
      do_eret();
      expect_grant("t5b");
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset("t5_rst");
      chk("sb_empty", 32'(grant_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
